// File: rtl/rd_stream_ctrl.sv
// Read side of an asynchronous FIFO: synchronizes the Gray write pointer,
// fetches words from the dual-port memory and presents them as a ready/valid stream.
module rd_stream_ctrl #(
  parameter int PTR_WIDTH  = 6,
  parameter int DATA_WIDTH = 8,
  parameter int AE_THRESH  = 4
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [PTR_WIDTH-1:0]  g_wptr,
  output logic [PTR_WIDTH-1:0]  g_rptr,
  output logic [PTR_WIDTH-2:0]  mem_raddr,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [PTR_WIDTH-1:0]  level,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  err
);

  localparam logic [PTR_WIDTH-1:0] AE_LIMIT = PTR_WIDTH'(AE_THRESH);
  localparam logic [PTR_WIDTH-1:0] DEPTH    = PTR_WIDTH'(1 << (PTR_WIDTH - 1));

  logic [PTR_WIDTH-1:0]  g_wptr_meta;
  logic [PTR_WIDTH-1:0]  g_wptr_sync;
  logic [PTR_WIDTH-1:0]  bin_wptr_sync;
  logic [PTR_WIDTH-1:0]  b_rptr;
  logic [PTR_WIDTH-1:0]  next_b;
  logic                  inflight;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  rd_idx;
  logic                  wr_idx;
  logic                  pop;
  logic                  push;
  logic [2:0]            occ;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      g_wptr_meta <= '0;
      g_wptr_sync <= '0;
    end else begin
      g_wptr_meta <= g_wptr;
      g_wptr_sync <= g_wptr_meta;
    end
  end

  // Gray to binary: each bit is the XOR of itself and all higher Gray bits.
  always_comb begin
    bin_wptr_sync = '0;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      bin_wptr_sync[i] = ^(g_wptr_sync >> i);
    end
  end

  assign empty        = (g_wptr_sync == g_rptr);
  assign level        = bin_wptr_sync - b_rptr;
  assign almost_empty = (level <= AE_LIMIT);
  assign mem_raddr    = b_rptr[PTR_WIDTH-2:0];

  assign pop     = m_valid & m_ready;
  assign push    = inflight;
  // Projected buffer occupancy counts the word already in flight, so a fetch
  // is only issued when a slot is guaranteed on arrival.
  assign occ     = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign mem_ren = !empty && (occ < 3'd2);
  assign next_b  = b_rptr + {{(PTR_WIDTH-1){1'b0}}, mem_ren};

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_rptr   <= '0;
      g_rptr   <= '0;
      inflight <= 1'b0;
      err      <= 1'b0;
    end else begin
      b_rptr   <= next_b;
      g_rptr   <= next_b ^ (next_b >> 1);
      inflight <= mem_ren;
      err      <= err | (level > DEPTH);
    end
  end

  // Two-entry ring buffer; head is rd_idx, tail is wr_idx.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      rd_idx    <= 1'b0;
      wr_idx    <= 1'b0;
      buf_count <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_idx] <= mem_rdata;
        wr_idx        <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      if (push && !pop) begin
        buf_count <= buf_count + 2'd1;
      end else if (pop && !push) begin
        buf_count <= buf_count - 2'd1;
      end
    end
  end

  assign m_valid = (buf_count != 2'd0);
  assign m_data  = buf_q[rd_idx];

endmodule

// File: tb/tb_rd_stream_ctrl.sv
// Self-checking bench for rd_stream_ctrl: memory and writer models, a word-order
// scoreboard, a vector table for occupancy flags and directed corner-case sequences.
module tb_rd_stream_ctrl;

  localparam int PW = 6;
  localparam int DW = 8;

  typedef struct {
    int             total;
    bit             ready;
    logic [PW-1:0]  lvl;
    bit             emp;
    bit             ae;
    bit             er;
  } vec_t;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic [PW-1:0] g_wptr = '0;
  logic [PW-1:0] g_rptr;
  logic [PW-2:0] mem_raddr;
  logic          mem_ren;
  logic [DW-1:0] mem_rdata = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [PW-1:0] level;
  logic          empty;
  logic          almost_empty;
  logic          err;

  rd_stream_ctrl #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .AE_THRESH(4)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .g_wptr(g_wptr), .g_rptr(g_rptr),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level), .empty(empty), .almost_empty(almost_empty), .err(err)
  );

  always #5 rclk = ~rclk;

  logic [DW-1:0] mem [32];
  always @(posedge rclk) begin
    if (mem_ren) mem_rdata <= mem[mem_raddr];
  end

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] wbin = '0;
  int            written = 0;
  logic [DW-1:0] exp_q [$];
  bit            sb_en = 1'b1;
  bit            hold_prev = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic [PW-1:0] prev_g = '0;
  bit            wrap_seen = 1'b0;
  int            ren_count = 0;
  vec_t          tv [9];

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] data);
    mem[wbin[PW-2:0]] = data;
    wbin    = wbin + 1'b1;
    written = written + 1;
    g_wptr  = gray(wbin);
    if (sb_en) exp_q.push_back(data);
  endtask

  task automatic applyStimulus(input bit do_write, input logic [DW-1:0] data, input bit ready);
    @(posedge rclk);
    #1;
    m_ready = ready;
    if (do_write) push_word(data);
  endtask

  task automatic do_reset();
    @(posedge rclk);
    #1;
    rrst_n  = 1'b0;
    wbin    = '0;
    written = 0;
    g_wptr  = '0;
    exp_q.delete();
    repeat (3) @(posedge rclk);
    #1;
    rrst_n = 1'b1;
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge rclk) begin
    if (!rrst_n) begin
      hold_prev = 1'b0;
      prev_g    = '0;
    end else begin
      if (hold_prev) begin
        checkOutput("stall_valid", m_valid, 1);
        checkOutput("stall_data", m_data, held_data);
      end
      if (m_valid && m_ready && sb_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_word: got %0d, expected no word at %0t", m_data, $time);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("[TB] FAIL data_order: got %0d, expected %0d at %0t", m_data, e, $time);
          end
        end
      end
      hold_prev = m_valid && !m_ready;
      held_data = m_data;
      if (prev_g == 6'b100000 && g_rptr == 6'b000000) wrap_seen = 1'b1;
      prev_g = g_rptr;
      if (mem_ren) ren_count++;
    end
  end

  initial begin
    int first_e;
    int gaps;
    int stale;

    tv[0] = '{0,  1'b0, 6'd0,  1'b1, 1'b1, 1'b0};
    tv[1] = '{1,  1'b0, 6'd0,  1'b1, 1'b1, 1'b0};
    tv[2] = '{2,  1'b0, 6'd0,  1'b1, 1'b1, 1'b0};
    tv[3] = '{6,  1'b0, 6'd4,  1'b0, 1'b1, 1'b0};
    tv[4] = '{7,  1'b0, 6'd5,  1'b0, 1'b0, 1'b0};
    tv[5] = '{34, 1'b0, 6'd32, 1'b0, 1'b0, 1'b0};
    tv[6] = '{35, 1'b0, 6'd33, 1'b0, 1'b0, 1'b1};
    tv[7] = '{40, 1'b0, 6'd38, 1'b0, 1'b0, 1'b1};
    tv[8] = '{40, 1'b1, 6'd0,  1'b1, 1'b1, 1'b1};

    // Reset values, both while held and after a quiet idle period.
    #2;
    checkOutput("rst_g_rptr", g_rptr, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_mem_ren", mem_ren, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_almost_empty", almost_empty, 1);
    checkOutput("rst_err", err, 0);
    do_reset();
    ren_count = 0;
    repeat (10) applyStimulus(1'b0, '0, 1'b0);
    @(negedge rclk);
    checkOutput("idle_empty", empty, 1);
    checkOutput("idle_almost_empty", almost_empty, 1);
    checkOutput("idle_m_valid", m_valid, 0);
    checkOutput("idle_ren_count", ren_count, 0);
    checkOutput("idle_g_rptr", g_rptr, 0);

    // Three words with the sink ready: first valid four edges after the first write.
    applyStimulus(1'b1, 8'hA1, 1'b1);
    first_e = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge rclk);
      #1;
      if (e == 1) push_word(8'hB2);
      if (e == 2) push_word(8'hC3);
      if (m_valid && first_e == 0) first_e = e;
    end
    checkOutput("latency_edges", first_e, 4);
    repeat (5) applyStimulus(1'b0, '0, 1'b1);
    @(negedge rclk);
    checkOutput("three_drained", exp_q.size(), 0);
    checkOutput("three_g_rptr", g_rptr, 2);
    checkOutput("three_level", level, 0);
    checkOutput("three_empty", empty, 1);

    // Backpressure: only two fetches while stalled, then back-to-back delivery.
    ren_count = 0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
    repeat (20) applyStimulus(1'b0, '0, 1'b0);
    @(negedge rclk);
    checkOutput("stall_ren_count", ren_count, 2);
    checkOutput("stall_head", m_data, exp_q[0]);
    checkOutput("stall_level", level, 8);
    applyStimulus(1'b0, '0, 1'b1);
    gaps = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      if (!m_valid) gaps++;
    end
    checkOutput("b2b_gaps", gaps, 0);
    repeat (5) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("b2b_drained", exp_q.size(), 0);

    // Random traffic long enough to wrap the read pointer more than once.
    wrap_seen = 1'b0;
    for (int c = 0; c < 600; c++) begin
      applyStimulus(($urandom_range(0, 3) != 0) && (written < 163) && (exp_q.size() < 30),
                    8'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (60) applyStimulus(1'b0, '0, 1'b1);
    @(negedge rclk);
    checkOutput("rand_drained", exp_q.size(), 0);
    checkOutput("rand_level", level, 0);
    checkOutput("rand_empty", empty, 1);
    checkOutput("rand_g_rptr", g_rptr, gray(wbin));
    checkOutput("rand_wrap_seen", wrap_seen, 1);

    // Reset with two words buffered: output drops at once, nothing stale afterwards.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b0);
    repeat (8) applyStimulus(1'b0, '0, 1'b0);
    @(negedge rclk);
    checkOutput("pre_reset_valid", m_valid, 1);
    @(posedge rclk);
    #1;
    rrst_n = 1'b0;
    #1;
    checkOutput("midrst_m_valid", m_valid, 0);
    checkOutput("midrst_mem_ren", mem_ren, 0);
    checkOutput("midrst_level", level, 0);
    checkOutput("midrst_empty", empty, 1);
    checkOutput("midrst_g_rptr", g_rptr, 0);
    do_reset();
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      @(negedge rclk);
      if (m_valid) stale++;
    end
    checkOutput("post_reset_stale", stale, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h90 + i), 1'b1);
    repeat (10) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("post_reset_drained", exp_q.size(), 0);

    // Occupancy table: two words are always pulled into the buffer while stalled,
    // so level trails the written count by two.
    do_reset();
    sb_en = 1'b0;
    foreach (tv[k]) begin
      while (written < tv[k].total) applyStimulus(1'b1, 8'(written), tv[k].ready);
      repeat (50) applyStimulus(1'b0, '0, tv[k].ready);
      @(negedge rclk);
      checkOutput($sformatf("tv%0d_level", k), level, tv[k].lvl);
      checkOutput($sformatf("tv%0d_empty", k), empty, tv[k].emp);
      checkOutput($sformatf("tv%0d_almost_empty", k), almost_empty, tv[k].ae);
      checkOutput($sformatf("tv%0d_err", k), err, tv[k].er);
    end

    do_reset();
    sb_en = 1'b1;
    @(negedge rclk);
    checkOutput("final_err_cleared", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
